// File: rtl/param_dp_pkg.sv
// Shared types for the parametrised single-bus datapath.
// Holds the opcode and sequencer encodings plus the legality check.
package param_dp_pkg;

    typedef enum logic [3:0] {
        OpMovi  = 4'd0,
        OpAdd   = 4'd1,
        OpSub   = 4'd2,
        OpAnd   = 4'd3,
        OpOr    = 4'd4,
        OpShl   = 4'd5,
        OpShra  = 4'd6,
        OpAddi  = 4'd7,
        OpMul   = 4'd8,
        OpMfhi  = 4'd9,
        OpMflo  = 4'd10,
        OpRsv11 = 4'd11,
        OpRsv12 = 4'd12,
        OpRsv13 = 4'd13,
        OpRsv14 = 4'd14,
        OpRsv15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StT1   = 2'd1,
        StT2   = 2'd2,
        StT3   = 2'd3
    } state_e;

    function automatic logic is_legal(op_e op);
        return op <= OpMflo;
    endfunction

endpackage

// File: rtl/param_dp_alu.sv
// Combinational ALU: combines Y with the bus value into a double-width Z.
// Non-MUL results occupy the low half; illegal opcodes yield zero.
module param_dp_alu
    import param_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   y_i,
    input  logic [DATA_W-1:0]   bus_i,
    input  logic [3:0]          op_i,
    output logic [2*DATA_W-1:0] z_o
);
    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]            amt;
    logic signed [2*DATA_W-1:0] y_ext;
    logic signed [2*DATA_W-1:0] b_ext;

    assign amt   = bus_i[SH_W-1:0];
    assign y_ext = {{DATA_W{y_i[DATA_W-1]}}, y_i};
    assign b_ext = {{DATA_W{bus_i[DATA_W-1]}}, bus_i};

    always_comb begin
        z_o = '0;
        case (op_e'(op_i))
            // Y is forced to zero for these moves, so a plain add passes the bus through
            OpMovi, OpAdd, OpAddi, OpMfhi, OpMflo: z_o[DATA_W-1:0] = y_i + bus_i;
            OpSub:  z_o[DATA_W-1:0] = y_i - bus_i;
            OpAnd:  z_o[DATA_W-1:0] = y_i & bus_i;
            OpOr:   z_o[DATA_W-1:0] = y_i | bus_i;
            OpShl:  z_o[DATA_W-1:0] = y_i << amt;
            OpShra: z_o[DATA_W-1:0] = $signed(y_i) >>> amt;
            OpMul:  z_o = y_ext * b_ext;
            default: z_o = '0;
        endcase
    end

endmodule

// File: rtl/param_bus_datapath_seq.sv
// Single-bus datapath with register file, Y/Z/HI/LO and a built-in T1..T3 sequencer
// that executes one register-transfer command per four cycles.
module param_bus_datapath_seq
    import param_dp_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter bit          R0_BA_MODE = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_ra,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_rb,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_rc,
    input  logic [DATA_W-1:0]           cmd_imm,
    output logic                        rsp_valid,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           rsp_result,
    output logic [DATA_W-1:0]           hi_out,
    output logic [DATA_W-1:0]           lo_out,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]           dbg_data
);
    localparam int unsigned REG_AW = $clog2(NUM_REGS);

    state_e              state_q;
    op_e                 op_q;
    logic [REG_AW-1:0]   ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   y_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q;
    logic [2*DATA_W-1:0] alu_z;
    logic [DATA_W-1:0]   bus;
    logic                rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_result_q;

    param_dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .y_i   (y_q),
        .bus_i (bus),
        .op_i  (op_q),
        .z_o   (alu_z)
    );

    always_comb begin
        bus = '0;
        unique case (state_q)
            StT1: begin
                if (op_q inside {OpMovi, OpMfhi, OpMflo}) begin
                    bus = '0;
                end else if (R0_BA_MODE && op_q == OpAddi && rb_q == '0) begin
                    bus = '0;
                end else begin
                    bus = regs_q[rb_q];
                end
            end
            StT2: begin
                case (op_q)
                    OpMovi, OpAddi: bus = imm_q;
                    OpMfhi:         bus = hi_q;
                    OpMflo:         bus = lo_q;
                    default:        bus = regs_q[rc_q];
                endcase
            end
            StT3:    bus = z_q[DATA_W-1:0];
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= OpMovi;
            ra_q         <= '0;
            rb_q         <= '0;
            rc_q         <= '0;
            imm_q        <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            y_q          <= '0;
            z_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        ra_q    <= cmd_ra;
                        rb_q    <= cmd_rb;
                        rc_q    <= cmd_rc;
                        imm_q   <= cmd_imm;
                        state_q <= StT1;
                    end
                end
                StT1: begin
                    y_q     <= bus;
                    state_q <= StT2;
                end
                StT2: begin
                    z_q     <= alu_z;
                    state_q <= StT3;
                end
                StT3: begin
                    if (is_legal(op_q)) begin
                        if (op_q == OpMul) begin
                            hi_q <= z_q[2*DATA_W-1:DATA_W];
                            lo_q <= bus;
                        end else begin
                            regs_q[ra_q] <= bus;
                        end
                    end
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= !is_legal(op_q);
                    rsp_result_q <= is_legal(op_q) ? bus : '0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_result = rsp_result_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_param_bus_datapath_seq.sv
// Directed bench: a 32-bit/16-reg R0-base build and a 16-bit/8-reg plain-R0 build
// driven from one command table, plus hand sequences for reset and illegal opcodes.
module tb_param_bus_datapath_seq;

    typedef struct {
        bit          sel;
        logic [3:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          chk_reg;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  op = '0, ra = '0, rb = '0, rc = '0, dbg = '0;
    logic [31:0] imm = '0;

    logic        ready_a, rv_a, re_a;
    logic [31:0] res_a, hi_a, lo_a, dbg_a;
    logic        ready_b, rv_b, re_b;
    logic [15:0] res_b, hi_b, lo_b, dbg_b;

    logic        ready_m, rv_m, re_m;
    logic [31:0] res_m, dbg_m;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    param_bus_datapath_seq #(
        .DATA_W (32), .NUM_REGS (16), .R0_BA_MODE (1'b1)
    ) dut_a (
        .clock (clock), .reset (reset),
        .cmd_valid (cmd_valid & ~sel), .cmd_ready (ready_a),
        .cmd_op (op), .cmd_ra (ra), .cmd_rb (rb), .cmd_rc (rc), .cmd_imm (imm),
        .rsp_valid (rv_a), .rsp_err (re_a), .rsp_result (res_a),
        .hi_out (hi_a), .lo_out (lo_a), .dbg_addr (dbg), .dbg_data (dbg_a)
    );

    param_bus_datapath_seq #(
        .DATA_W (16), .NUM_REGS (8), .R0_BA_MODE (1'b0)
    ) dut_b (
        .clock (clock), .reset (reset),
        .cmd_valid (cmd_valid & sel), .cmd_ready (ready_b),
        .cmd_op (op), .cmd_ra (ra[2:0]), .cmd_rb (rb[2:0]), .cmd_rc (rc[2:0]),
        .cmd_imm (imm[15:0]),
        .rsp_valid (rv_b), .rsp_err (re_b), .rsp_result (res_b),
        .hi_out (hi_b), .lo_out (lo_b), .dbg_addr (dbg[2:0]), .dbg_data (dbg_b)
    );

    assign ready_m = sel ? ready_b : ready_a;
    assign rv_m    = sel ? rv_b : rv_a;
    assign re_m    = sel ? re_b : re_a;
    assign res_m   = sel ? {16'h0, res_b} : res_a;
    assign dbg_m   = sel ? {16'h0, dbg_b} : dbg_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command and wait (bounded) for the response pulse.
    task automatic run_cmd(input bit s, input logic [3:0] o, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c, input logic [31:0] im,
                           output logic [31:0] res, output logic err,
                           output int lat, output int busy);
        @(negedge clock);
        sel = s; op = o; ra = a; rb = b; rc = c; imm = im;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        lat  = 0;
        busy = 0;
        while (lat < 10 && !rv_m) begin
            if (!ready_m) busy++;
            @(posedge clock);
            #1;
            lat++;
        end
        res = res_m;
        err = re_m;
    endtask

    task automatic read_reg(input bit s, input logic [3:0] a, output logic [31:0] v);
        sel = s;
        dbg = a;
        #1;
        v = dbg_m;
    endtask

    function automatic vec_t mk(bit s, logic [3:0] o, logic [3:0] a, logic [3:0] b,
                                logic [3:0] c, logic [31:0] im, logic [31:0] e, bit cr);
        vec_t v;
        v.sel = s; v.op = o; v.ra = a; v.rb = b; v.rc = c;
        v.imm = im; v.exp = e; v.chk_reg = cr;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, v;
        logic        err;
        int          lat, busy;
        bit          seen;

        // sel, op, ra, rb, rc, imm, expected result, check Ra via debug port
        vecs.push_back(mk(0, 4'd0,  4'd3,  4'd0,  4'd0, 32'h12,         32'h12,         1));
        vecs.push_back(mk(0, 4'd0,  4'd1,  4'd0,  4'd0, 32'd7,          32'd7,          1));
        vecs.push_back(mk(0, 4'd0,  4'd2,  4'd0,  4'd0, 32'd5,          32'd5,          1));
        vecs.push_back(mk(0, 4'd2,  4'd4,  4'd1,  4'd2, 32'h0,          32'd2,          1));
        vecs.push_back(mk(0, 4'd2,  4'd4,  4'd2,  4'd1, 32'h0,          32'hFFFF_FFFE,  1));
        vecs.push_back(mk(0, 4'd1,  4'd9,  4'd1,  4'd2, 32'h0,          32'hC,          1));
        vecs.push_back(mk(0, 4'd3,  4'd10, 4'd1,  4'd2, 32'h0,          32'h5,          1));
        vecs.push_back(mk(0, 4'd4,  4'd11, 4'd1,  4'd2, 32'h0,          32'h7,          1));
        vecs.push_back(mk(0, 4'd5,  4'd12, 4'd1,  4'd2, 32'h0,          32'hE0,         1));
        vecs.push_back(mk(0, 4'd0,  4'd13, 4'd0,  4'd0, 32'h8000_0000,  32'h8000_0000,  1));
        vecs.push_back(mk(0, 4'd6,  4'd14, 4'd13, 4'd2, 32'h0,          32'hFC00_0000,  1));
        vecs.push_back(mk(0, 4'd1,  4'd4,  4'd4,  4'd4, 32'h0,          32'hFFFF_FFFC,  1));
        vecs.push_back(mk(0, 4'd0,  4'd1,  4'd0,  4'd0, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  1));
        vecs.push_back(mk(0, 4'd0,  4'd2,  4'd0,  4'd0, 32'd3,          32'd3,          1));
        vecs.push_back(mk(0, 4'd8,  4'd15, 4'd1,  4'd2, 32'h0,          32'hFFFF_FFFA,  0));
        vecs.push_back(mk(0, 4'd9,  4'd5,  4'd0,  4'd0, 32'h0,          32'hFFFF_FFFF,  1));
        vecs.push_back(mk(0, 4'd10, 4'd6,  4'd0,  4'd0, 32'h0,          32'hFFFF_FFFA,  1));
        vecs.push_back(mk(0, 4'd0,  4'd0,  4'd0,  4'd0, 32'h100,        32'h100,        1));
        vecs.push_back(mk(0, 4'd7,  4'd6,  4'd0,  4'd0, 32'd4,          32'd4,          1));
        vecs.push_back(mk(0, 4'd1,  4'd7,  4'd0,  4'd0, 32'h0,          32'h200,        1));
        vecs.push_back(mk(0, 4'd7,  4'd8,  4'd7,  4'd0, 32'hFFFF_FFFF,  32'h1FF,        1));
        vecs.push_back(mk(1, 4'd0,  4'd1,  4'd0,  4'd0, 32'h8000,       32'h8000,       1));
        vecs.push_back(mk(1, 4'd0,  4'd2,  4'd0,  4'd0, 32'd15,         32'd15,         1));
        vecs.push_back(mk(1, 4'd6,  4'd3,  4'd1,  4'd2, 32'h0,          32'hFFFF,       1));
        vecs.push_back(mk(1, 4'd0,  4'd2,  4'd0,  4'd0, 32'd16,         32'd16,         1));
        vecs.push_back(mk(1, 4'd5,  4'd4,  4'd1,  4'd2, 32'h0,          32'h8000,       1));
        vecs.push_back(mk(1, 4'd0,  4'd0,  4'd0,  4'd0, 32'h100,        32'h100,        1));
        vecs.push_back(mk(1, 4'd7,  4'd6,  4'd0,  4'd0, 32'd4,          32'h104,        1));
        vecs.push_back(mk(1, 4'd1,  4'd7,  4'd0,  4'd0, 32'h0,          32'h200,        1));
        vecs.push_back(mk(1, 4'd2,  4'd5,  4'd0,  4'd2, 32'h0,          32'hF0,         1));

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset cmd_ready", {31'h0, ready_a}, 32'd1);
        check("reset rsp_valid", {31'h0, rv_a}, 32'd0);
        check("reset rsp_err", {31'h0, re_a}, 32'd0);
        check("reset rsp_result", res_a, 32'h0);
        check("reset hi", hi_a, 32'h0);
        check("reset lo", lo_a, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd(vecs[i].sel, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rc,
                    vecs[i].imm, res, err, lat, busy);
            check($sformatf("vec%0d latency", i), lat, 32'd3);
            check($sformatf("vec%0d busy", i), busy, 32'd3);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d err", i), {31'h0, err}, 32'd0);
            if (vecs[i].chk_reg) begin
                read_reg(vecs[i].sel, vecs[i].ra, v);
                check($sformatf("vec%0d reg", i), v, vecs[i].exp);
            end
        end

        sel = 1'b0;
        #1;
        check("mul hi", hi_a, 32'hFFFF_FFFF);
        check("mul lo", lo_a, 32'hFFFF_FFFA);
        read_reg(0, 4'd15, v);
        check("mul no reg write", v, 32'h0);

        // Reset lands on the T2->T3 edge of an in-flight ADD.
        @(negedge clock);
        sel = 1'b0; op = 4'd1; ra = 4'd8; rb = 4'd1; rc = 4'd2; imm = '0;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset cmd_ready", {31'h0, ready_a}, 32'd1);
        check("midreset rsp_valid", {31'h0, rv_a}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            if (rv_a) seen = 1'b1;
        end
        check("midreset no response", {31'h0, seen}, 32'd0);
        read_reg(0, 4'd8, v);
        check("midreset R8", v, 32'h0);
        read_reg(0, 4'd7, v);
        check("midreset R7 cleared", v, 32'h0);
        check("midreset hi", hi_a, 32'h0);
        check("midreset lo", lo_a, 32'h0);

        run_cmd(0, 4'd0, 4'd2, 4'd0, 4'd0, 32'h55, res, err, lat, busy);
        check("pre-illegal movi", res, 32'h55);
        run_cmd(0, 4'd13, 4'd2, 4'd1, 4'd1, 32'h77, res, err, lat, busy);
        check("illegal latency", lat, 32'd3);
        check("illegal err", {31'h0, err}, 32'd1);
        check("illegal result", res, 32'h0);
        read_reg(0, 4'd2, v);
        check("illegal no write", v, 32'h55);
        check("illegal hi", hi_a, 32'h0);
        check("illegal lo", lo_a, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
